// File: rtl/led_channel_driver.sv
// led_channel_driver: multi-channel LED driver with a shared tick prescaler and PWM counter,
// plus per-channel OFF/ON/BLINK/PWM configuration through a valid/ready write port.
module led_channel_driver #(
  parameter int NUM_CH  = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16,
  parameter int DUTY_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic              cfg_err,
  output logic              tick,
  output logic [NUM_CH-1:0] led
);
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = $clog2(DIV);
  localparam int CH_N = 2 ** CH_W;
  // one bit per encodable channel index, set only for channels that exist
  localparam logic [CH_N-1:0] CH_OK = {CH_N{1'b1}} >> (CH_N - NUM_CH);

  logic [PS_W-1:0]   r_ps;
  logic [DUTY_W-1:0] r_pwm;
  logic              r_tick;
  logic              r_ready;
  logic              r_err;
  logic [1:0]        r_mode   [NUM_CH];
  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [DUTY_W-1:0] r_duty   [NUM_CH];
  logic [CNT_W-1:0]  r_phase  [NUM_CH];
  logic [NUM_CH-1:0] r_blink;
  logic [NUM_CH-1:0] r_led;
  logic [NUM_CH-1:0] w_drive;
  logic [NUM_CH-1:0] w_last;
  logic              w_acc;
  logic              w_ok;
  logic              w_wrap;

  assign w_acc  = cfg_valid & r_ready;
  assign w_ok   = CH_OK[cfg_ch];
  assign w_wrap = en && (r_ps == PS_W'(DIV - 1));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_last[i]  = r_phase[i] == ((r_period[i] == '0) ? '0 : r_period[i] - 1'b1);
      w_drive[i] = r_mode[i][1] ? (r_mode[i][0] ? (r_pwm < r_duty[i]) : r_blink[i]) : r_mode[i][0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ps     <= '0;
      r_pwm    <= '0;
      r_tick   <= 1'b0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_mode   <= '{default: '0};
      r_period <= '{default: '0};
      r_duty   <= '{default: '0};
      r_phase  <= '{default: '0};
      r_blink  <= '0;
      r_led    <= '0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_acc & ~w_ok;
      r_tick  <= w_wrap;
      if (en) begin
        r_ps  <= w_wrap ? '0 : r_ps + 1'b1;
        r_pwm <= r_pwm + 1'b1;
        r_led <= w_drive;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        // a write on a tick edge restarts the channel and suppresses the toggle
        if (w_acc && w_ok && cfg_ch == CH_W'(i)) begin
          r_mode[i]   <= cfg_mode;
          r_period[i] <= cfg_period;
          r_duty[i]   <= cfg_duty;
          r_phase[i]  <= '0;
          r_blink[i]  <= 1'b0;
        end else if (r_tick) begin
          r_phase[i] <= w_last[i] ? '0 : r_phase[i] + 1'b1;
          r_blink[i] <= r_blink[i] ^ w_last[i];
        end
      end
    end
  end

  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;
  assign tick      = r_tick;
  assign led       = r_led;
endmodule
